// File: rtl/parallel_serial_c_if.sv
// parallel_serial_c_if: byte handshake between the datapath and the serializer
interface parallel_serial_c_if;
   logic       valid_in;
   logic [7:0] Data_in;
   logic       ready_out;
   modport master (output valid_in, output Data_in, input ready_out);
   modport slave  (input valid_in, input Data_in, output ready_out);
endinterface

// File: rtl/parallel_serial_c.sv
// parallel_serial_c: byte-to-serial transmitter, MSB first, COMMA sync preamble then idle filler (optional PS_BC_COLLISION_FLAG_EN adds bc_collision)
module parallel_serial_c #(
   parameter int         NUM_SYNC = 4,
   parameter logic [7:0] COMMA    = 8'hBC
) (
   input  logic                       clk_32f,
   input  logic                       reset,
   parallel_serial_c_if.slave         bus,
   output logic                       Data_out,
   output logic                       active_out
`ifdef PS_BC_COLLISION_FLAG_EN
   ,
   output logic                       bc_collision
`endif
);
   localparam int SW = $clog2(NUM_SYNC + 1);
   typedef enum logic {SYNC, RUN} state_t;
   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [SW-1:0] sync_cnt_q, sync_cnt_d;
   logic          hold_full_q, hold_full_d;
   logic [7:0]    hold_data_q, hold_data_d;
   logic [7:0]    tx_byte_q, tx_byte_d;
   logic          data_out_q, data_out_d;
   logic          active_q, active_d;
   logic          bc_q, bc_d;
   logic          boundary, accept, use_hold;
   logic [7:0]    next_byte;
   assign bus.ready_out = !hold_full_q;
   assign Data_out      = data_out_q;
   assign active_out    = active_q;
`ifdef PS_BC_COLLISION_FLAG_EN
   assign bc_collision  = bc_q;
`endif
   // Next state: byte selection at boundaries, bit shifting otherwise, and the holding buffer
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q + 3'd1;
      sync_cnt_d  = sync_cnt_q;
      hold_full_d = hold_full_q;
      hold_data_d = hold_data_q;
      tx_byte_d   = tx_byte_q;
      active_d    = active_q;
      boundary    = bit_cnt_q == 3'd0;
      accept      = bus.valid_in && !hold_full_q;
      use_hold    = boundary && state_q == RUN && hold_full_q;
      next_byte   = use_hold ? hold_data_q : COMMA;
      data_out_d  = boundary ? next_byte[7] : tx_byte_q[3'd7 - bit_cnt_q];
      bc_d        = accept && bus.Data_in == COMMA;
      if (boundary) begin
         tx_byte_d = next_byte;
         if (state_q == SYNC) begin
            sync_cnt_d = sync_cnt_q + SW'(1);
            if (sync_cnt_q == SW'(NUM_SYNC - 1)) begin
               state_d  = RUN;
               active_d = 1'b1;
            end
         end
      end
      if (use_hold) hold_full_d = 1'b0;
      if (accept) begin
         hold_full_d = 1'b1;
         hold_data_d = bus.Data_in;
      end
   end
   // State registers; reset aborts the current byte and drops any held byte
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         state_q     <= SYNC;
         bit_cnt_q   <= '0;
         sync_cnt_q  <= '0;
         hold_full_q <= 1'b0;
         hold_data_q <= '0;
         tx_byte_q   <= '0;
         data_out_q  <= 1'b0;
         active_q    <= 1'b0;
         bc_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         sync_cnt_q  <= sync_cnt_d;
         hold_full_q <= hold_full_d;
         hold_data_q <= hold_data_d;
         tx_byte_q   <= tx_byte_d;
         data_out_q  <= data_out_d;
         active_q    <= active_d;
         bc_q        <= bc_d;
      end
   end
endmodule

// File: doc/parallel_serial_c.md
Name: parallel_serial_c

Overview:
- Transmit side of the 8-bit serial link: accepts parallel bytes through a valid/ready handshake and emits one bit per clk_32f cycle, MSB first.
- After reset, sends NUM_SYNC consecutive COMMA bytes so the far-end deserializer can lock. After that it sends user bytes when available and COMMA as the idle filler.
- Sits between the byte-level datapath and the serial line, feeding the matching serial-to-parallel receiver.

Parameters:
- NUM_SYNC, 4, number of COMMA bytes sent after reset before any user byte (must be >= 1).
- COMMA, 8'hBC, alignment/idle byte value.

Ports:
- clk_32f  input  1  bit-rate clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  Data_in holds a byte to send.
- Data_in  input  8  parallel byte.
- ready_out  output  1  holding buffer empty; byte accepted on an edge with valid_in && ready_out.
- Data_out  output  1  serial bit, registered.
- active_out  output  1  high once the sync preamble has been fully loaded (state RUN).

Behaviour:
- Reset (reset=1 sampled at a posedge) gives:
  - Data_out=0, active_out=0, state=SYNC, bit_cnt=0, sync_cnt=0.
  - hold_full=0, tx_byte=0.
  - ready_out=1 as soon as reset is low, because ready_out = !hold_full (combinational from a register).
- Reset mid-byte aborts the current byte and discards any held byte. The next active edge restarts the full sync preamble.
- bit_cnt is 3 bits and wraps 7->0. A boundary edge is an active edge (reset=0) with bit_cnt==0.
- At a boundary edge:
  - Select next byte N: in SYNC, N=COMMA. In RUN, N=hold_data if hold_full, else COMMA.
  - tx_byte<=N, Data_out<=N[7], bit_cnt<=1.
  - If N came from the hold register, hold_full<=0.
- At a non-boundary edge: Data_out<=tx_byte[7-bit_cnt], bit_cnt<=bit_cnt+1.
- Result: each byte occupies exactly 8 consecutive Data_out cycles, MSB first.
- State machine:
  - SYNC: at each boundary sync_cnt increments. At the boundary where sync_cnt==NUM_SYNC-1, the last comma is loaded and state<=RUN, active_out<=1.
  - RUN: remains until reset. No other exits.
- Handshake:
  - Accept on an edge with valid_in && ready_out: hold_data<=Data_in, hold_full<=1.
  - Accepting during SYNC is legal; the byte waits for the first RUN boundary.
  - Data_in is don't-care when valid_in=0.
- Simultaneous events:
  - Accept edge coinciding with a boundary while hold is empty: the byte goes to hold only. COMMA is sent this boundary; the byte goes out at the next boundary (no bypass).
  - Boundary consuming hold: ready_out was 0 at that edge, so no accept can collide. ready_out rises after the edge.
- Back-to-back throughput: one byte per 8 cycles, provided valid_in is re-asserted before the next boundary.
- A user byte equal to COMMA is transmitted unchanged; the receiver treats it as idle.

Optional Feature:
- Macro: PS_BC_COLLISION_FLAG_EN.
- Defined:
  - Adds output bc_collision (1 bit, reset 0).
  - Pulses high for exactly one cycle on the edge after a byte equal to COMMA is accepted through the handshake.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then valid_in=0 for 48 cycles -> Data_out repeats 1,0,1,1,1,1,0,0. ready_out=1 throughout. active_out rises after active edge 25 (NUM_SYNC=4).
- Offer 0xA5 during sync (accepted at edge 2) -> ready_out=0 until edge 33. Edges 33-40 give Data_out 1,0,1,0,0,1,0,1. COMMA follows.
- Stream 0x00, 0xFF, 0x3C back-to-back in RUN -> 24 consecutive bits 00000000 11111111 00111100, with no idle comma between them.
- Accept 0x81 exactly at a RUN boundary edge with hold empty -> COMMA sent first, then 1,0,0,0,0,0,0,1.
- Assert reset for 1 cycle at bit 4 of byte 0x5A with 0x11 held -> 0x11 is discarded and ready_out=1. active_out=0 and Data_out=0 immediately after the reset edge. Four fresh commas are sent before any data.
- With PS_BC_COLLISION_FLAG_EN, accept 0xBC -> bc_collision=1 for one cycle. Accept 0xBD -> bc_collision stays 0.
